// File: rtl/wrr_ingress_packer.sv
// wrr_ingress_packer: packs SOP/EOP framed beats into one packet strobe for the WRR FIFO, dropping malformed packets
//   clk, rst_n                                    : clock, async active-low reset
//   in_vld/in_sop/in_eop/in_prior/in_data/in_rdy  : beat bus (transfer on in_vld && in_rdy)
//   data_vld/prior/Queue                          : one-cycle packet strobe, priority, packed payload (beat 0 in LSBs)
//   err_drop/drop_cnt                             : drop pulse, saturating drop counter
module wrr_ingress_packer #(
  parameter int DATAPACK_BIT = 1024,
  parameter int BEAT_BIT     = 64,
  parameter int PRIORITY_BIT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_vld,
  input  logic                    in_sop,
  input  logic                    in_eop,
  input  logic [PRIORITY_BIT-1:0] in_prior,
  input  logic [BEAT_BIT-1:0]     in_data,
  output logic                    in_rdy,
  output logic                    data_vld,
  output logic [PRIORITY_BIT-1:0] prior,
  output logic [DATAPACK_BIT-1:0] Queue,
  output logic                    err_drop,
  output logic [7:0]              drop_cnt
);
  localparam int BEATS = DATAPACK_BIT / BEAT_BIT;
  localparam int CW = $clog2(BEATS) + 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  typedef enum logic [1:0] {IDLE, COLLECT, DISCARD, EMIT} state_t;
  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [DATAPACK_BIT-1:0] queue_q;
  logic [PRIORITY_BIT-1:0] prior_q;
  logic                    data_vld_q, err_q;
  logic [7:0]              drop_cnt_q;
  logic                    acc, drop;
  int                      idx;
  assign acc = in_vld && state_q != EMIT;
  // abort by SOP, orphan beat in IDLE, or last slot filled without EOP
  assign drop = acc && ((in_sop && state_q == COLLECT) || (!in_sop && state_q == IDLE) ||
                        (!in_sop && !in_eop && state_q == COLLECT && cnt_q == LAST));
  assign idx = int'(cnt_q) * BEAT_BIT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      queue_q    <= '0;
      prior_q    <= '0;
      data_vld_q <= 1'b0;
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      data_vld_q <= 1'b0;
      err_q      <= drop;
      drop_cnt_q <= drop_cnt_q + 8'(drop && drop_cnt_q != 8'hFF);
      if (state_q == EMIT) state_q <= IDLE;
      else if (in_vld) begin
        if (in_sop) begin
          queue_q    <= {{(DATAPACK_BIT-BEAT_BIT){1'b0}}, in_data};
          prior_q    <= in_prior;
          cnt_q      <= CW'(1);
          state_q    <= in_eop ? EMIT : COLLECT;
          data_vld_q <= in_eop;
        end else if (state_q == DISCARD) begin
          if (in_eop) state_q <= IDLE;
        end else if (state_q == COLLECT) begin
          queue_q[idx +: BEAT_BIT] <= in_data;
          if (in_eop) begin
            state_q    <= EMIT;
            data_vld_q <= 1'b1;
          end else if (cnt_q == LAST) state_q <= DISCARD;
          else cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  assign in_rdy   = state_q != EMIT;
  assign data_vld = data_vld_q;
  assign prior    = prior_q;
  assign Queue    = queue_q;
  assign err_drop = err_q;
  assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_wrr_ingress_packer.sv
// tb_wrr_ingress_packer: directed self-checking bench for wrr_ingress_packer
module tb_wrr_ingress_packer;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_vld = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [2:0]    in_prior = '0;
  logic [63:0]   in_data = '0;
  logic          in_rdy, data_vld, err_drop;
  logic [2:0]    prior;
  logic [1023:0] queue;
  logic [7:0]    drop_cnt;
  int checks = 0, errors = 0;
  int vld_total = 0, err_total = 0;
  int vld_base, err_base;
  wrr_ingress_packer dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop),
    .in_prior(in_prior), .in_data(in_data), .in_rdy(in_rdy), .data_vld(data_vld),
    .prior(prior), .Queue(queue), .err_drop(err_drop), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (data_vld) vld_total++;
    if (err_drop) err_total++;
  end
  task automatic beat(input logic s, input logic e, input logic [2:0] p, input logic [63:0] d);
    in_vld = 1'b1; in_sop = s; in_eop = e; in_prior = p; in_data = d;
    @(posedge clk); #1;
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_prior = 3'd0; in_data = '0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic mark();
    vld_base = vld_total; err_base = err_total;
  endtask
  task automatic test_reset();
    #2;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL rst_in_rdy got %0b exp 1", in_rdy); end
    checks++; if (data_vld !== 1'b0) begin errors++; $display("FAIL rst_data_vld got %0b exp 0", data_vld); end
    checks++; if (prior !== 3'd0) begin errors++; $display("FAIL rst_prior got %0d exp 0", prior); end
    checks++; if (queue !== '0) begin errors++; $display("FAIL rst_queue got nonzero exp 0"); end
    checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL rst_err_drop got %0b exp 0", err_drop); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rst_drop_cnt got %0d exp 0", drop_cnt); end
    @(negedge clk); rst_n = 1'b1;
    idle(2);
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL rst_rel_in_rdy got %0b exp 1", in_rdy); end
  endtask
  task automatic test_full_packet();
    mark();
    for (int k = 0; k < 16; k++) beat(k == 0, k == 15, k == 0 ? 3'd5 : 3'd7, 64'(k));
    checks++; if (data_vld !== 1'b1) begin errors++; $display("FAIL full_vld got %0b exp 1", data_vld); end
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL full_in_rdy got %0b exp 0", in_rdy); end
    checks++; if (queue[63:0] !== 64'd0) begin errors++; $display("FAIL full_beat0 got %0h exp 0", queue[63:0]); end
    checks++; if (queue[575:512] !== 64'd8) begin errors++; $display("FAIL full_beat8 got %0h exp 8", queue[575:512]); end
    checks++; if (queue[1023:960] !== 64'd15) begin errors++; $display("FAIL full_beat15 got %0h exp f", queue[1023:960]); end
    checks++; if (prior !== 3'd5) begin errors++; $display("FAIL full_prior got %0d exp 5", prior); end
    idle(1);
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_after got %0b exp 1", in_rdy); end
    checks++; if (data_vld !== 1'b0) begin errors++; $display("FAIL full_vld_after got %0b exp 0", data_vld); end
    checks++; if (queue[1023:960] !== 64'd15) begin errors++; $display("FAIL full_hold got %0h exp f", queue[1023:960]); end
    checks++; if (vld_total - vld_base !== 1) begin errors++; $display("FAIL full_pulses got %0d exp 1", vld_total - vld_base); end
  endtask
  task automatic test_single_beat();
    beat(1'b1, 1'b1, 3'd0, 64'hA5A5);
    checks++; if (data_vld !== 1'b1) begin errors++; $display("FAIL single_vld got %0b exp 1", data_vld); end
    checks++; if (queue !== {960'b0, 64'hA5A5}) begin errors++; $display("FAIL single_queue got %0h exp a5a5", queue[63:0]); end
    checks++; if (prior !== 3'd0) begin errors++; $display("FAIL single_prior got %0d exp 0", prior); end
    in_vld = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_prior = 3'd3; in_data = 64'h77;
    idle(1);
    checks++; if (data_vld !== 1'b0) begin errors++; $display("FAIL b2b_gap_vld got %0b exp 0", data_vld); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL b2b_gap_rdy got %0b exp 1", in_rdy); end
    idle(1);
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    checks++; if (data_vld !== 1'b1) begin errors++; $display("FAIL b2b_vld got %0b exp 1", data_vld); end
    checks++; if (queue !== {960'b0, 64'h77} || prior !== 3'd3) begin errors++; $display("FAIL b2b_pkt got %0h/%0d exp 77/3", queue[63:0], prior); end
    idle(1);
  endtask
  task automatic test_abort_by_sop();
    mark();
    beat(1'b1, 1'b0, 3'd6, 64'hD0);
    beat(1'b0, 1'b0, 3'd6, 64'hD1);
    beat(1'b0, 1'b0, 3'd6, 64'hD2);
    beat(1'b1, 1'b0, 3'd2, 64'h100);
    checks++; if (err_drop !== 1'b1) begin errors++; $display("FAIL abort_err got %0b exp 1", err_drop); end
    for (int k = 1; k < 16; k++) beat(1'b0, k == 15, 3'd0, 64'h100 + 64'(k));
    checks++; if (data_vld !== 1'b1 || prior !== 3'd2) begin errors++; $display("FAIL abort_pkt got vld %0b prior %0d exp 1/2", data_vld, prior); end
    checks++; if (queue[127:0] !== {64'h101, 64'h100}) begin errors++; $display("FAIL abort_low got %0h exp 101_100", queue[127:0]); end
    checks++; if (queue[1023:960] !== 64'h10F) begin errors++; $display("FAIL abort_top got %0h exp 10f", queue[1023:960]); end
    idle(1);
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL abort_cnt got %0d exp 1", drop_cnt); end
    checks++; if (vld_total - vld_base !== 1 || err_total - err_base !== 1) begin errors++; $display("FAIL abort_pulses got %0d/%0d exp 1/1", vld_total - vld_base, err_total - err_base); end
  endtask
  task automatic test_overlong();
    mark();
    for (int k = 0; k < 16; k++) beat(k == 0, 1'b0, 3'd4, 64'h200 + 64'(k));
    checks++; if (err_drop !== 1'b1) begin errors++; $display("FAIL over_err got %0b exp 1", err_drop); end
    for (int k = 16; k < 20; k++) beat(1'b0, k == 19, 3'd4, 64'h200 + 64'(k));
    idle(1);
    checks++; if (vld_total - vld_base !== 0 || err_total - err_base !== 1) begin errors++; $display("FAIL over_pulses got %0d/%0d exp 0/1", vld_total - vld_base, err_total - err_base); end
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL over_cnt got %0d exp 2", drop_cnt); end
    for (int k = 0; k < 4; k++) beat(k == 0, k == 3, 3'd1, 64'h300 + 64'(k));
    checks++; if (data_vld !== 1'b1 || prior !== 3'd1) begin errors++; $display("FAIL short_pkt got vld %0b prior %0d exp 1/1", data_vld, prior); end
    checks++; if (queue[255:192] !== 64'h303 || queue[1023:256] !== '0) begin errors++; $display("FAIL short_queue got %0h exp 303 with zero tail", queue[255:192]); end
    idle(1);
  endtask
  task automatic test_orphan_saturation();
    mark();
    for (int k = 0; k < 300; k++) beat(1'b0, k[0], 3'd0, 64'(k));
    idle(1);
    checks++; if (err_total - err_base !== 300) begin errors++; $display("FAIL orphan_pulses got %0d exp 300", err_total - err_base); end
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL orphan_sat got %0d exp 255", drop_cnt); end
    checks++; if (vld_total - vld_base !== 0) begin errors++; $display("FAIL orphan_vld got %0d exp 0", vld_total - vld_base); end
  endtask
  task automatic test_reset_mid_packet();
    for (int k = 0; k < 8; k++) beat(k == 0, 1'b0, 3'd7, 64'hEE00 + 64'(k));
    rst_n = 1'b0;
    #2;
    checks++; if (in_rdy !== 1'b1 || data_vld !== 1'b0 || err_drop !== 1'b0) begin errors++; $display("FAIL midrst_ctl got rdy %0b vld %0b err %0b exp 1/0/0", in_rdy, data_vld, err_drop); end
    checks++; if (queue !== '0 || prior !== 3'd0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL midrst_data got prior %0d cnt %0d exp 0/0", prior, drop_cnt); end
    @(negedge clk); rst_n = 1'b1;
    idle(1);
    mark();
    for (int k = 0; k < 16; k++) beat(k == 0, k == 15, 3'd3, 64'h400 + 64'(k));
    checks++; if (data_vld !== 1'b1 || prior !== 3'd3) begin errors++; $display("FAIL midrst_pkt got vld %0b prior %0d exp 1/3", data_vld, prior); end
    checks++; if (queue[511:448] !== 64'h407 || queue[63:0] !== 64'h400) begin errors++; $display("FAIL midrst_queue got %0h/%0h exp 407/400", queue[511:448], queue[63:0]); end
    idle(1);
    checks++; if (err_total - err_base !== 0 || vld_total - vld_base !== 1) begin errors++; $display("FAIL midrst_pulses got err %0d vld %0d exp 0/1", err_total - err_base, vld_total - vld_base); end
  endtask
  initial begin
    test_reset();
    test_full_packet();
    test_single_beat();
    test_abort_by_sop();
    test_overlong();
    test_orphan_saturation();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wrr_ingress_packer.md
# wrr_ingress_packer

Ingress stage directly upstream of the weighted-round-robin priority FIFO. It collects narrow bus beats (SOP/EOP framed, priority tagged at SOP) into one DATAPACK_BIT-wide packet and presents it to the FIFO as a single-cycle `data_vld` pulse with `prior` and `Queue`. It also polices framing: malformed or overlong packets are discarded and counted.

## Interface
- `DATAPACK_BIT`, 1024: width of an assembled packet; equals FIFO `Queue` width.
- `BEAT_BIT`, 64: input beat width; `DATAPACK_BIT` is an integer multiple of it.
- `PRIORITY_BIT`, 3: priority tag width; equals FIFO `prior` width.
- Derived: `BEATS = DATAPACK_BIT/BEAT_BIT` (16 by default); beat counter width is `$clog2(BEATS)+1`.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous active-low reset.
- `in_vld` in 1: beat valid.
- `in_sop` in 1: first beat of a packet.
- `in_eop` in 1: last beat of a packet.
- `in_prior` in PRIORITY_BIT: priority tag, sampled only on the SOP beat.
- `in_data` in BEAT_BIT: beat payload.
- `in_rdy` out 1: beat accept.
- `data_vld` out 1: one-cycle packet strobe to the FIFO.
- `prior` out PRIORITY_BIT: packet priority.
- `Queue` out DATAPACK_BIT: assembled packet.
- `err_drop` out 1: one-cycle pulse per discarded packet or orphan beat.
- `drop_cnt` out 8: saturating drop counter.

## Operation
- **Transfer rule:** a beat transfers when `in_vld && in_rdy`. `in_rdy` is 1 in IDLE, COLLECT and DISCARD, and 0 in EMIT. It is decoded from state, so `in_rdy` = 1 from reset.
- **Packing:** beat k of a packet is written to `Queue[k*BEAT_BIT +: BEAT_BIT]`, with beat 0 in the LSBs. The assembly register is cleared on every accepted SOP, and the SOP beat is written in the same cycle. Unwritten beats of short packets therefore read 0.
- **States:**
  - **IDLE:**
    - Accepted beat with `in_sop`: latch `in_prior` and write beat 0, with count set to 1.
      - If `in_eop` is also set, go to EMIT.
      - Otherwise go to COLLECT.
    - Accepted beat without `in_sop` is an orphan: pulse `err_drop`, stay in IDLE.
  - **COLLECT:**
    - Accepted beat with `in_sop`: abort the current packet with an `err_drop` pulse, then restart as an SOP beat (clear, latch priority, count = 1). If that beat also has `in_eop`, go to EMIT.
    - Accepted beat without `in_sop`: write it at index count.
      - If `in_eop` is set, go to EMIT (short or exact packet).
      - Else if the new count equals BEATS, go to DISCARD with an `err_drop` pulse (overlong: the last slot was filled without EOP).
      - Else increment count.
  - **DISCARD:**
    - Accepted beats are ignored.
    - A beat with `in_eop` returns the block to IDLE.
    - A beat with `in_sop` restarts as in IDLE, with no additional `err_drop` pulse.
  - **EMIT:** `data_vld` = 1 for exactly one cycle. `Queue` and `prior` hold the packet. Next state is IDLE.
- **Drop counter:** `drop_cnt` increments on every `err_drop` pulse and saturates at 255.
- **Output stability:** `Queue` and `prior` are registered and hold their last value after EMIT until the next SOP clears the assembly register. The FIFO samples them only while `data_vld` = 1.
- **No backpressure from the FIFO:** the FIFO drops writes to a full queue itself.

## Timing
- **Reset values:** state IDLE, `in_rdy` 1, `data_vld` 0, `prior` 0, `Queue` 0, `err_drop` 0, `drop_cnt` 0, count 0.
- **Latency:** EOP beat accepted at edge T gives `data_vld` = 1 during cycle T+1. The earliest next SOP is accepted at edge T+2. Sustained throughput is BEATS+1 cycles per full packet; a single-beat packet takes 2 cycles.
- **`err_drop` timing:** the pulse is registered and asserts in the cycle after the offending beat is accepted.
- **`in_vld` low:** a cycle with `in_vld` = 0 changes nothing; gaps are allowed mid-packet.
- **Reset mid-packet:** state returns to IDLE immediately. The partial packet is lost without an `err_drop` pulse, and no `data_vld` is produced.
- **Reset during EMIT:** the `data_vld` pulse is cut. The FIFO is reset by the same `rst_n`.

## Test plan
- **Full packet:** 16 beats with values 0..15, SOP on beat 0, EOP on beat 15, `in_prior` = 5 → one `data_vld` pulse the cycle after beat 15. `Queue[63:0]` = 0 and `Queue[1023:960]` = 15, `prior` = 5, `in_rdy` = 0 for that one cycle only.
- **Single beat:** one beat with SOP and EOP, data `64'hA5A5`, prior 0 → `Queue` = `{960'b0, 64'hA5A5}`. `data_vld` rises 1 cycle later; the next SOP is accepted 2 cycles after the first.
- **Abort by SOP:** 3 beats, then a SOP with prior 2 and 16 beats → one `err_drop` pulse, `drop_cnt` = 1. Exactly one `data_vld` pulse, carrying prior 2 and only the second packet's data.
- **Overlong packet:** 20 beats with EOP on beat 19 → `err_drop` pulse after beat 15, no `data_vld`, `drop_cnt` += 1. The following valid packet emits normally.
- **Orphan beats and saturation:** 300 orphan beats without SOP in IDLE → 300 `err_drop` pulses, `drop_cnt` stops at 255, no `data_vld`.
- **Reset mid-packet:** `rst_n` low after beat 7 → all outputs at reset values. A subsequent 16-beat packet emits with no stale data from the aborted packet.
